// File: rtl/data_mem_ctrl.sv
// Handshaked RV64I/RV32I data memory: byte-strobed word array, load extension,
// store lane steering and access-error reporting, one response per accepted request.
module data_mem_ctrl #(
  parameter int          XLEN        = 64,
  parameter int          ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err
);

  localparam int unsigned NB     = XLEN / 8;
  localparam int          OFF_W  = $clog2(NB);
  localparam int          IDX_W  = ADDR_W - OFF_W;
  localparam int          MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];
  logic [XLEN-1:0]   rd_word;
  logic [1:0]        err_q;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;
  logic              ld_ok_q;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [1:0]        size;
  logic              illegal, misal, oor;
  logic [1:0]        err;
  logic              accept;
  logic [NB-1:0]     strb_base, strb;
  logic [XLEN-1:0]   wdata_sh, lane, ext;

  assign off     = req_addr[OFF_W-1:0];
  assign idx     = req_addr[ADDR_W-1:OFF_W];
  assign mem_idx = idx[MEM_AW-1:0];
  assign size    = req_funct3[1:0];

  // req_ready is forced low during reset so nothing is accepted or written then.
  assign req_ready  = rst_n && ((state == IDLE) || resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid ? err_q : '0;

  always_comb begin
    if (req_we)
      illegal = req_funct3[2] || (XLEN == 32 && req_funct3 == 3'b011);
    else
      illegal = (req_funct3 == 3'b111) ||
                (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
    case (size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = req_addr[0];
      2'd2:    misal = |req_addr[1:0];
      default: misal = |req_addr[2:0];
    endcase
    oor = (32'(idx) >= DEPTH_WORDS);
    if (illegal)    err = 2'b11;
    else if (misal) err = 2'b01;
    else if (oor)   err = 2'b10;
    else            err = 2'b00;
  end

  always_comb begin
    strb_base = '0;
    for (int unsigned b = 0; b < NB; b++)
      strb_base[b] = (b < (32'd1 << size));
    strb     = strb_base << off;
    wdata_sh = req_wdata << {off, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && err == 2'b00)
      for (int unsigned b = 0; b < NB; b++)
        if (strb[b]) mem[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    if (accept && !oor)
      rd_word <= mem[mem_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      err_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      ld_ok_q <= 1'b0;
    end else if (accept) begin
      state   <= RESP;
      err_q   <= err;
      f3_q    <= req_funct3;
      off_q   <= off;
      ld_ok_q <= !req_we && (err == 2'b00);
    end else if (resp_ready) begin
      state   <= IDLE;
    end
  end

  always_comb begin
    lane = rd_word >> {off_q, 3'b000};
    ext  = '0;
    case (f3_q)
      3'b000:  ext = XLEN'($signed(lane[7:0]));
      3'b001:  ext = XLEN'($signed(lane[15:0]));
      3'b010:  ext = XLEN'($signed(lane[31:0]));
      3'b011:  ext = lane;
      3'b100:  ext = XLEN'(lane[7:0]);
      3'b101:  ext = XLEN'(lane[15:0]);
      3'b110:  ext = XLEN'(lane[31:0]);
      default: ext = '0;
    endcase
    resp_rdata = (resp_valid && ld_ok_q) ? ext : '0;
  end

endmodule
